// File: rtl/bcd_countdown_timer.sv
// Single-digit BCD countdown with prescaled tick, load/start/pause control.
// Digit bits drive the seven-segment decoder inputs x0..x3 directly.
module bcd_countdown_timer #(
    parameter int TICK_DIV      = 50000000,
    parameter int START_DEFAULT = 9
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       start,
    input  logic       pause,
    output logic       q0,
    output logic       q1,
    output logic       q2,
    output logic       q3,
    output logic       zero,
    output logic       running,
    output logic       done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
    localparam logic [3:0] START_VAL = 4'(START_DEFAULT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [3:0]    count, count_n;
    logic [3:0]    reload, reload_n;
    logic [PW-1:0] psc, psc_n;
    logic          start_prev, pause_prev;
    logic          start_rise, pause_rise;
    logic          tick;
    logic [3:0]    load_clamp;

    assign start_rise = start & ~start_prev;
    assign pause_rise = pause & ~pause_prev;
    assign tick       = (state == RUN) && (psc == TICK_MAX);
    assign load_clamp = (load_val > 4'd9) ? 4'd9 : load_val;

    // Next-state, next-count and prescaler control; load overrides everything.
    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload;
        psc_n    = psc;
        if (load) begin
            count_n  = load_clamp;
            reload_n = load_clamp;
            state_n  = IDLE;
            psc_n    = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_rise) begin
                        psc_n   = '0;
                        state_n = (count != 4'd0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    psc_n = tick ? '0 : psc + 1'b1;
                    if (tick && count <= 4'd1) begin
                        count_n = 4'd0;
                        state_n = DONE;
                    end else begin
                        if (tick) count_n = count - 4'd1;
                        if (pause_rise) state_n = PAUSE;
                    end
                end
                PAUSE: begin
                    if (start_rise || pause_rise) state_n = RUN;
                end
                DONE: begin
                    if (start_rise) begin
                        count_n = reload;
                        if (reload != 4'd0) begin
                            state_n = RUN;
                            psc_n   = '0;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State, digit, prescaler, edge history and registered status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= START_VAL;
            reload     <= START_VAL;
            psc        <= '0;
            start_prev <= 1'b0;
            pause_prev <= 1'b0;
            running    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            reload     <= reload_n;
            psc        <= psc_n;
            start_prev <= start;
            pause_prev <= pause;
            running    <= (state_n == RUN);
            done       <= (state_n == DONE);
        end
    end

    assign q0   = count[0];
    assign q1   = count[1];
    assign q2   = count[2];
    assign q3   = count[3];
    assign zero = (count == 4'd0);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer (TICK_DIV=4 and TICK_DIV=1).
// Inputs change 1 time unit after each rising edge; outputs checked there.
module tb_bcd_countdown_timer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic       pause;

    logic       a_q0, a_q1, a_q2, a_q3, a_zero, a_run, a_done;
    logic       b_q0, b_q1, b_q2, b_q3, b_zero, b_run, b_done;
    logic [3:0] qa, qb;

    int ntests = 0;
    int nfail  = 0;

    assign qa = {a_q3, a_q2, a_q1, a_q0};
    assign qb = {b_q3, b_q2, b_q1, b_q0};

    always #5 clk = ~clk;

    bcd_countdown_timer #(.TICK_DIV(4), .START_DEFAULT(9)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .load_val(load_val),
        .start(start), .pause(pause),
        .q0(a_q0), .q1(a_q1), .q2(a_q2), .q3(a_q3),
        .zero(a_zero), .running(a_run), .done(a_done)
    );

    bcd_countdown_timer #(.TICK_DIV(1), .START_DEFAULT(9)) dut1 (
        .clk(clk), .reset_n(reset_n), .load(load), .load_val(load_val),
        .start(start), .pause(pause),
        .q0(b_q0), .q1(b_q1), .q2(b_q2), .q3(b_q3),
        .zero(b_zero), .running(b_run), .done(b_done)
    );

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        ntests++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] q,
                         input logic r, input logic d, input logic z);
        chk({tag, ".q"}, qa, q);
        chk({tag, ".running"}, a_run, r);
        chk({tag, ".done"}, a_done, d);
        chk({tag, ".zero"}, a_zero, z);
    endtask

    initial begin
        reset_n  = 1'b0;
        load     = 1'b0;
        load_val = 4'd0;
        start    = 1'b0;
        pause    = 1'b0;
        #12;
        chk_a("reset", 4'd9, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        cyc(1);

        // 1: full countdown from 9
        start = 1'b1;
        cyc(1);
        chk_a("t1_start", 4'd9, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        cyc(3);
        chk("t1_hold3", qa, 4'd9);
        cyc(1);
        chk("t1_q8", qa, 4'd8);
        for (int v = 7; v >= 1; v--) begin
            cyc(4);
            chk($sformatf("t1_q%0d", v), qa, 4'(v));
        end
        cyc(4);
        chk_a("t1_end", 4'd0, 1'b0, 1'b1, 1'b1);
        cyc(8);
        chk_a("t1_hold0", 4'd0, 1'b0, 1'b1, 1'b1);

        // 2: clamp, load 3, countdown, restart from DONE
        load     = 1'b1;
        load_val = 4'd12;
        cyc(1);
        chk_a("t2_clamp", 4'd9, 1'b0, 1'b0, 1'b0);
        load_val = 4'd3;
        cyc(1);
        chk("t2_load3", qa, 4'd3);
        load  = 1'b0;
        start = 1'b1;
        cyc(1);
        chk("t2_run", a_run, 1'b1);
        start = 1'b0;
        cyc(4);
        chk("t2_q2", qa, 4'd2);
        cyc(4);
        chk("t2_q1", qa, 4'd1);
        cyc(4);
        chk_a("t2_done", 4'd0, 1'b0, 1'b1, 1'b1);
        start = 1'b1;
        cyc(1);
        chk_a("t2_restart", 4'd3, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        cyc(4);
        chk("t2_rq2", qa, 4'd2);
        cyc(8);
        chk_a("t2_rdone", 4'd0, 1'b0, 1'b1, 1'b1);

        // 3: pause mid-period, prescaler held across pause
        start = 1'b1;
        cyc(1);
        chk_a("t3_run", 4'd3, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        cyc(1);
        pause = 1'b1;
        cyc(1);
        chk_a("t3_paused", 4'd3, 1'b0, 1'b0, 1'b0);
        pause = 1'b0;
        cyc(20);
        chk_a("t3_held", 4'd3, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        cyc(1);
        chk_a("t3_resume", 4'd3, 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        cyc(1);
        chk("t3_r1", qa, 4'd3);
        cyc(1);
        chk("t3_r2", qa, 4'd2);

        // 4: load beats start in RUN; start held across reset release
        load     = 1'b1;
        load_val = 4'd5;
        start    = 1'b1;
        cyc(1);
        chk_a("t4_load", 4'd5, 1'b0, 1'b0, 1'b0);
        load  = 1'b0;
        start = 1'b0;
        cyc(4);
        chk_a("t4_idle", 4'd5, 1'b0, 1'b0, 1'b0);
        start   = 1'b1;
        reset_n = 1'b0;
        #1;
        chk_a("t4_rst", 4'd9, 1'b0, 1'b0, 1'b0);
        cyc(1);
        reset_n = 1'b1;
        cyc(1);
        chk_a("t4_rise", 4'd9, 1'b1, 1'b0, 1'b0);
        cyc(4);
        chk("t4_q8", qa, 4'd8);
        start = 1'b0;

        // 5: zero load goes straight to DONE; single step; pause on last tick
        load     = 1'b1;
        load_val = 4'd0;
        cyc(1);
        chk_a("t5_load0", 4'd0, 1'b0, 1'b0, 1'b1);
        load  = 1'b0;
        start = 1'b1;
        cyc(1);
        chk_a("t5_done0", 4'd0, 1'b0, 1'b1, 1'b1);
        start    = 1'b0;
        load     = 1'b1;
        load_val = 4'd1;
        cyc(1);
        chk_a("t5_load1", 4'd1, 1'b0, 1'b0, 1'b0);
        load  = 1'b0;
        start = 1'b1;
        cyc(1);
        chk("t5_run", a_run, 1'b1);
        start = 1'b0;
        cyc(3);
        chk("t5_q1", qa, 4'd1);
        cyc(1);
        chk_a("t5_q0", 4'd0, 1'b0, 1'b1, 1'b1);
        load = 1'b1;
        cyc(1);
        load  = 1'b0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(3);
        pause = 1'b1;
        cyc(1);
        chk_a("t5_pdone", 4'd0, 1'b0, 1'b1, 1'b1);
        pause = 1'b0;

        // 6: TICK_DIV=1 decrements every RUN cycle; async reset mid-count
        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        chk("t6_rst_q", qb, 4'd9);
        start = 1'b1;
        cyc(1);
        chk("t6_run", b_run, 1'b1);
        chk("t6_q9", qb, 4'd9);
        start = 1'b0;
        cyc(1);
        chk("t6_q8", qb, 4'd8);
        cyc(1);
        chk("t6_q7", qb, 4'd7);
        cyc(1);
        chk("t6_q6", qb, 4'd6);
        reset_n = 1'b0;
        #1;
        chk("t6_arst_q", qb, 4'd9);
        chk("t6_arst_run", b_run, 1'b0);
        cyc(1);
        reset_n = 1'b1;
        cyc(2);
        chk("t6_idle_q", qb, 4'd9);
        chk("t6_idle_run", b_run, 1'b0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(9);
        chk("t6_end_q", qb, 4'd0);
        chk("t6_end_done", b_done, 1'b1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Single-digit BCD countdown counter: the stage directly upstream of the seven-segment decoder on the 4-bit decrementer board.
- Holds a 0-9 value, decrements it once per prescaled tick while running, and presents the digit as four bits that wire straight to decoder inputs x0..x3.
- Provides load, start and pause control, and terminal-count (done) signalling for the board-level demo.

Parameters:
- TICK_DIV, 50000000: clock cycles per decrement tick (1 Hz at 50 MHz). Legal range is 1 or more; 1 means a tick on every RUN cycle.
- START_DEFAULT, 9: digit value after reset. Legal range is 0-9.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- load  input  1  synchronous level; loads load_val on any cycle it is high.
- load_val  input  4  BCD value to load; 10-15 clamp to 9.
- start  input  1  level, rising-edge detected internally.
- pause  input  1  level, rising-edge detected internally.
- q0  output  1  digit bit 0 (LSB), to decoder x0.
- q1  output  1  digit bit 1, to decoder x1.
- q2  output  1  digit bit 2, to decoder x2.
- q3  output  1  digit bit 3 (MSB), to decoder x3.
- zero  output  1  high when the digit equals 0 (combinational from the count register).
- running  output  1  high in RUN.
- done  output  1  high in DONE.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - count = START_DEFAULT; reload = START_DEFAULT.
  - state = IDLE; prescaler = 0; start_prev = pause_prev = 0.
  - running = 0; done = 0; zero = (START_DEFAULT==0).
  - Reset mid-RUN aborts immediately with no partial decrement.
- Edge detect:
  - start_rise = start & ~start_prev, with start_prev registered every cycle; pause_rise is formed the same way.
  - A level already high when reset releases yields one rise on the first cycle.
- Prescaler:
  - Width clog2(TICK_DIV), minimum 1 bit.
  - Increments only in RUN. tick = (prescaler==TICK_DIV-1) in RUN; the prescaler wraps to 0 on tick.
  - Cleared on load, on entry to RUN from IDLE or DONE, and on reset.
  - Held (not cleared) in PAUSE, so a resumed count continues its partial period.
- Load (highest priority, any state):
  - count and reload = clamp(load_val); state goes to IDLE.
  - Start and pause rises in that cycle are discarded.
- FSM states are IDLE, RUN, PAUSE, DONE.
  - IDLE: on start_rise, go to RUN if count!=0, otherwise go to DONE. pause_rise is ignored.
  - RUN:
    - On tick with count>1: count = count-1.
    - On tick with count==1: count = 0 and go to DONE.
    - On pause_rise: go to PAUSE. If tick occurs in the same cycle, the decrement is still applied; if that decrement reaches 0, DONE takes precedence over PAUSE.
    - start_rise is ignored.
  - PAUSE: start_rise or pause_rise goes to RUN, and the count is held.
  - DONE: count stays 0. On start_rise, count = reload; go to RUN if reload!=0, otherwise stay in DONE.
- Arithmetic: count is 4 bits and only ever holds 0-9. There is no wrap below 0; the count halts at 0.
- Outputs: q3..q0 = count register (registered, glitch-free); running and done are registered decodes of state.
- Latency:
  - The first decrement occurs TICK_DIV cycles after the edge on which RUN is entered; subsequent decrements follow every TICK_DIV cycles.
  - A load is visible on q3..q0 one cycle after the sampling edge.

Test Plan (TICK_DIV=4 unless noted):
1. Reset release -> q=9, zero=0, running=0, done=0. Next, pulse start -> running=1; q goes 8,7,...,1,0 at 4-cycle intervals; done=1 and zero=1 in the same cycle q=0; q then holds 0.
2. load=1 with load_val=12 -> q=9 (clamped). Next, load_val=3 then start -> q goes 2, 1, 0, then done; a second start in DONE -> q=3, running=1, countdown repeats.
3. Pause two cycles into a period: pause rise -> running=0, q held for 20 cycles; start rise -> RUN; the next decrement arrives 2 cycles later (prescaler held, not cleared).
4. load and start rising in the same cycle while in RUN -> state IDLE, q = load_val, running=0. Also, start held high across reset release -> exactly one rise, counting begins.
5. load_val=0 then start -> DONE immediately, no RUN cycles. Then load_val=1 and start -> one tick later q=0 and done=1. Separately, pause rise on the tick that reaches 0 -> state DONE, not PAUSE.
6. TICK_DIV=1: q decrements on every cycle of RUN. Also, reset asserted mid-count -> q=9 asynchronously, state IDLE.
